// File: rtl/float_cvt_wh_pkg.sv
// -----------------------------------------------------------------------------
// fpu_types_pkg
//  Shared FPU conversion types: rounding-mode encodings, binary16 special
//  encodings, int32 saturation constants, the half unpack record, the
//  conversion FSM state type and the rounding-increment helper.
// -----------------------------------------------------------------------------
package fpu_types_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [15:0] HALF_INF  = 16'h7C00;
    localparam logic [15:0] HALF_INFN = 16'hFC00;

    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ROUND,
        ST_OUT
    } cvt_state_t;

    // Unpacked binary16: unbiased exponent (-14..16) and 11-bit significand
    // with the hidden bit made explicit.
    typedef struct packed {
        logic              sign;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
        logic signed [5:0] exp;
        logic [10:0]       sig;
    } half_info_t;

    // Round-up decision from guard/sticky/lsb; reserved modes truncate.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic g, input logic s,
                                       input logic lsb);
        logic inc;
        case (rm)
            RM_RNE:  inc = g & (s | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | s);
            RM_RUP:  inc = ~sign & (g | s);
            RM_RMM:  inc = g;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/float_cvt_wh_if.sv
// -----------------------------------------------------------------------------
// float_cvt_wh_if
//  Request/response bundle of the half->int32 converter.
//  Request : in_valid, in_ready, float16[15:0], rm[2:0] (+ is_unsigned when
//            CVT_UNSIGNED_EN is defined)
//  Response: out_valid, out_ready, int32[31:0], out_nv, out_nx
//  master = issue side, slave = converter.
// -----------------------------------------------------------------------------
interface float_cvt_wh_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] float16;
    logic [2:0]  rm;
`ifdef CVT_UNSIGNED_EN
    logic        is_unsigned;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int32;
    logic        out_nv;
    logic        out_nx;

    modport master (
        output in_valid, float16, rm, out_ready,
`ifdef CVT_UNSIGNED_EN
        output is_unsigned,
`endif
        input  in_ready, out_valid, int32, out_nv, out_nx
    );

    modport slave (
        input  in_valid, float16, rm, out_ready,
`ifdef CVT_UNSIGNED_EN
        input  is_unsigned,
`endif
        output in_ready, out_valid, int32, out_nv, out_nx
    );
endinterface

// File: rtl/float_cvt_wh_half_unpack.sv
// -----------------------------------------------------------------------------
// half_unpack
//  Combinational binary16 classification and field extraction.
//  half_i : binary16 operand
//  info_o : sign, NaN/inf/zero class, unbiased exponent, significand
//           (subnormals report exp=-14 with hidden bit 0)
// -----------------------------------------------------------------------------
module half_unpack
    import fpu_types_pkg::*;
(
    input  logic [15:0] half_i,
    output half_info_t  info_o
);

    always_comb begin
        info_o.sign    = half_i[15];
        info_o.is_inf  = (half_i == HALF_INF) || (half_i == HALF_INFN);
        info_o.is_nan  = (half_i[14:10] == 5'h1F) && (half_i[9:0] != 10'd0);
        info_o.is_zero = (half_i[14:0] == 15'd0);
        if (half_i[14:10] == 5'd0) begin
            info_o.exp = -6'sd14;
            info_o.sig = {1'b0, half_i[9:0]};
        end else begin
            info_o.exp = $signed({1'b0, half_i[14:10]}) - 6'sd15;
            info_o.sig = {1'b1, half_i[9:0]};
        end
    end

endmodule

// File: rtl/float_cvt_wh.sv
// -----------------------------------------------------------------------------
// float_cvt_wh
//  binary16 -> signed int32 conversion (fcvt.w.h) with an iterative right
//  alignment shifter moving SHIFT_STEP bits per cycle.
//  CLK, nRST : clock (rising edge), asynchronous active-low reset
//  bus       : float_cvt_wh_if.slave (valid/ready request and response)
//  Optional  : CVT_UNSIGNED_EN adds bus.is_unsigned for fcvt.wu.h.
// -----------------------------------------------------------------------------
module float_cvt_wh
    import fpu_types_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic           CLK,
    input  logic           nRST,
    float_cvt_wh_if.slave  bus
);

    localparam logic [3:0] STEP = 4'(SHIFT_STEP);

    cvt_state_t  state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic        guard_q, guard_d, sticky_q, sticky_d;
    logic        sign_q, sign_d, uns_q, uns_d;
    logic [2:0]  rm_q, rm_d;
    logic [3:0]  rem_q, rem_d;
    logic [31:0] int32_q, int32_d;
    logic        nv_q, nv_d, nx_q, nx_d;

    half_info_t        unp;
    logic              uns_in;
    logic signed [6:0] e_ext, rsh;
    logic [2:0]        lsh_amt;
    logic [3:0]        step_amt;
    logic [31:0]       sh_mag;
    logic              sh_g, sh_s;
    logic              rnd_inc, inexact;
    logic [31:0]       rnd_mag;

    half_unpack u_unpack (.half_i(bus.float16), .info_o(unp));

`ifdef CVT_UNSIGNED_EN
    assign uns_in = bus.is_unsigned;
`else
    assign uns_in = 1'b0;
`endif

    assign e_ext    = {unp.exp[5], unp.exp};
    assign rsh      = 7'sd10 - e_ext;
    assign lsh_amt  = 3'(e_ext - 7'sd10);
    assign step_amt = (rem_q < STEP) ? rem_q : STEP;
    assign rnd_inc  = round_inc(rm_q, sign_q, guard_q, sticky_q, mag_q[0]);
    assign rnd_mag  = mag_q + {31'd0, rnd_inc};
    assign inexact  = guard_q | sticky_q;

    // NOTE: every register, datapath included, is cleared by reset so a
    // reset mid-operation leaves no stale result visible on the outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            sign_q   <= 1'b0;
            uns_q    <= 1'b0;
            rm_q     <= RM_RNE;
            rem_q    <= '0;
            int32_q  <= '0;
            nv_q     <= 1'b0;
            nx_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // same pre-edge values.
            state_q  <= state_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
            uns_q    <= uns_d;
            rm_q     <= rm_d;
            rem_q    <= rem_d;
            int32_q  <= int32_d;
            nv_q     <= nv_d;
            nx_q     <= nx_d;
        end
    end

    // One SHIFT cycle: move step_amt bits right through guard into sticky.
    always_comb begin
        // NOTE: defaults first so no path through the block infers a latch.
        sh_mag = mag_q;
        sh_g   = guard_q;
        sh_s   = sticky_q;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (4'(i) < step_amt) begin
                sh_s   = sh_s | sh_g;
                sh_g   = sh_mag[0];
                sh_mag = sh_mag >> 1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        sign_d   = sign_q;
        uns_d    = uns_q;
        rm_d     = rm_q;
        rem_d    = rem_q;
        int32_d  = int32_q;
        nv_d     = nv_q;
        nx_d     = nx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = unp.sign;
                    uns_d    = uns_in;
                    rm_d     = bus.rm;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    rem_d    = '0;
                    mag_d    = {21'd0, unp.sig};
                    nv_d     = 1'b0;
                    nx_d     = 1'b0;
                    if (unp.is_nan || (unp.is_inf && !unp.sign)) begin
                        int32_d = uns_in ? UINT32_MAX : INT32_MAX;
                        nv_d    = 1'b1;
                        state_d = ST_OUT;
                    end else if (unp.is_inf) begin
                        int32_d = uns_in ? 32'd0 : INT32_MIN;
                        nv_d    = 1'b1;
                        state_d = ST_OUT;
                    end else if (unp.is_zero) begin
                        int32_d = '0;
                        state_d = ST_OUT;
                    end else if (e_ext >= 7'sd10) begin
                        // Left alignment is at most 5 bits and exact: done here.
                        mag_d   = {21'd0, unp.sig} << lsh_amt;
                        state_d = ST_ROUND;
                    end else begin
                        // Beyond 12 bits everything is already in sticky.
                        rem_d   = (rsh > 7'sd12) ? 4'd12 : rsh[3:0];
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                mag_d    = sh_mag;
                guard_d  = sh_g;
                sticky_d = sh_s;
                rem_d    = rem_q - step_amt;
                if (rem_d == 4'd0) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                nv_d = 1'b0;
                nx_d = inexact;
                if (!uns_q) begin
                    int32_d = sign_q ? (~rnd_mag + 32'd1) : rnd_mag;
                end else if (sign_q && (rnd_mag != 32'd0)) begin
                    int32_d = '0;
                    nv_d    = 1'b1;
                    nx_d    = 1'b0;
                end else begin
                    int32_d = sign_q ? 32'd0 : rnd_mag;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_OUT);
        bus.int32     = int32_q;
        bus.out_nv    = nv_q;
        bus.out_nx    = nx_q;
    end

endmodule

// File: tb/tb_float_cvt_wh.sv
module tb_float_cvt_wh;

    localparam int STEP = 4;
    localparam int MAX_WAIT = 40;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    float_cvt_wh_if bus ();

    float_cvt_wh #(.SHIFT_STEP(STEP)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] h;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        nv;
        logic        nx;
        int          lat;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: exact value scaled by 2^24, rounded with plain integer math.
    function automatic void ref_model(input logic [15:0] h, input logic [2:0] r,
                                      output logic [31:0] res, output logic nv,
                                      output logic nx, output int lat);
        logic   sgn, inc;
        int     ex, e, n;
        longint v, ip, fr, half_ulp;
        sgn = h[15];
        ex  = int'(h[14:10]);
        res = '0; nv = 1'b0; nx = 1'b0; lat = 1;
        if (ex == 31) begin
            nv  = 1'b1;
            res = ((h[9:0] != 10'd0) || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
            return;
        end
        if (h[14:0] == 15'd0) return;
        if (ex == 0) begin
            v = longint'(h[9:0]);
            e = -14;
        end else begin
            v = longint'(1024 + int'(h[9:0])) << (ex - 1);
            e = ex - 15;
        end
        ip = v >> 24;
        fr = v % (longint'(1) << 24);
        half_ulp = longint'(1) << 23;
        case (r)
            3'd0:    inc = (fr > half_ulp) || ((fr == half_ulp) && ip[0]);
            3'd2:    inc = sgn && (fr != 0);
            3'd3:    inc = !sgn && (fr != 0);
            3'd4:    inc = (fr >= half_ulp);
            default: inc = 1'b0;
        endcase
        ip  = ip + longint'(inc);
        res = 32'(sgn ? -ip : ip);
        nx  = (fr != 0);
        if (e >= 10) lat = 2;
        else begin
            n   = (10 - e > 12) ? 12 : 10 - e;
            lat = 2 + (n + STEP - 1) / STEP;
        end
    endfunction

    task automatic do_op(input string tag, input logic [15:0] h, input logic [2:0] r,
                         input logic [31:0] exp_res, input logic exp_nv,
                         input logic exp_nx, input int exp_lat, input int hold);
        int lat;
        string nm;
        nm = $sformatf("%s h=%04h rm=%0d", tag, h, r);
        @(negedge CLK);
        bus.in_valid = 1'b1;
        bus.float16  = h;
        bus.rm       = r;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        repeat (hold) begin @(posedge CLK); #1; end
        check({nm, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, " int32"}, bus.int32, exp_res);
        check({nm, " nv"}, 32'(bus.out_nv), 32'(exp_nv));
        check({nm, " nx"}, 32'(bus.out_nx), 32'(exp_nx));
        @(negedge CLK);
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.out_ready = 1'b0;
        check({nm, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] h;
        logic [2:0]  r;
        logic [31:0] m_res;
        logic        m_nv, m_nx;
        int          m_lat;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.float16 = '0;
        bus.rm = '0;

        tbl[0]  = '{16'h3C00, 3'd0, 32'h0000_0001, 1'b0, 1'b0, 5};
        tbl[1]  = '{16'h4100, 3'd0, 32'h0000_0002, 1'b0, 1'b1, 5};
        tbl[2]  = '{16'h4100, 3'd4, 32'h0000_0003, 1'b0, 1'b1, 5};
        tbl[3]  = '{16'hC100, 3'd2, 32'hFFFF_FFFD, 1'b0, 1'b1, 5};
        tbl[4]  = '{16'h7BFF, 3'd1, 32'h0000_FFE0, 1'b0, 1'b0, 2};
        tbl[5]  = '{16'h7E00, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        tbl[6]  = '{16'hFC00, 3'd0, 32'h8000_0000, 1'b1, 1'b0, 1};
        tbl[7]  = '{16'h0001, 3'd3, 32'h0000_0001, 1'b0, 1'b1, 5};
        tbl[8]  = '{16'h7C00, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        tbl[9]  = '{16'h8000, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 1};
        tbl[10] = '{16'h3E00, 3'd0, 32'h0000_0002, 1'b0, 1'b1, 5};
        tbl[11] = '{16'hBE00, 3'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 5};
        tbl[12] = '{16'h3800, 3'd0, 32'h0000_0000, 1'b0, 1'b1, 5};
        tbl[13] = '{16'hB800, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 5};
        tbl[14] = '{16'h3800, 3'd5, 32'h0000_0000, 1'b0, 1'b1, 5};
        tbl[15] = '{16'h6400, 3'd0, 32'h0000_0400, 1'b0, 1'b0, 2};
        tbl[16] = '{16'h4900, 3'd3, 32'h0000_000A, 1'b0, 1'b0, 4};
        tbl[17] = '{16'hFBFF, 3'd1, 32'hFFFF_0020, 1'b0, 1'b0, 2};
        tbl[18] = '{16'h8001, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 5};

        repeat (3) @(posedge CLK);
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset int32", bus.int32, 32'd0);
        check("reset nv", 32'(bus.out_nv), 32'd0);
        check("reset nx", 32'(bus.out_nx), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 19; i++)
            do_op("table", tbl[i].h, tbl[i].rm, tbl[i].res, tbl[i].nv, tbl[i].nx, tbl[i].lat, 0);

        // Backpressure: result held, new request ignored while in OUT.
        @(negedge CLK);
        bus.in_valid = 1'b1; bus.float16 = 16'h4100; bus.rm = 3'd4;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        for (int w = 0; w < MAX_WAIT && !bus.out_valid; w++) begin @(posedge CLK); #1; end
        @(negedge CLK);
        bus.in_valid = 1'b1; bus.float16 = 16'h3C00; bus.rm = 3'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            check("bp int32", bus.int32, 32'd3);
            check("bp nx", 32'(bus.out_nx), 32'd1);
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge CLK);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.out_ready = 1'b0;
        @(posedge CLK); #1;
        check("bp ignored in_valid out_valid", 32'(bus.out_valid), 32'd0);
        check("bp ignored in_valid in_ready", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of SHIFT.
        @(negedge CLK);
        bus.in_valid = 1'b1; bus.float16 = 16'h3C00; bus.rm = 3'd0;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        check("rst mid-shift out_valid", 32'(bus.out_valid), 32'd0);
        check("rst mid-shift in_ready", 32'(bus.in_ready), 32'd1);
        check("rst mid-shift int32", bus.int32, 32'd0);
        check("rst mid-shift nx", 32'(bus.out_nx), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        do_op("after reset", 16'h3C00, 3'd0, 32'd1, 1'b0, 1'b0, 5, 0);

        // Randomized operands against the reference model.
        for (int k = 0; k < 300; k++) begin
            h = 16'($urandom);
            r = 3'($urandom_range(0, 7));
            ref_model(h, r, m_res, m_nv, m_nx, m_lat);
            do_op("random", h, r, m_res, m_nv, m_nx, m_lat, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
